pipeline_controller: RTL and testbench

Hazard and sequencing controller for the five-stage pipeline (IF/ID/EX/MEM/WB). It keeps a shadow occupancy pipe of in-flight instructions and stalls IF/ID with a bubble into EX on read-after-write hazards. It flushes the wrong-path instructions in ID and EX when MEM redirects the PC. On the halt instruction (32'hFFFFFFFF) it drains the pipeline, then sequences a word-by-word dump of MainMemory.

---
 rtl/pipeline_controller.sv | 135 +++++++++++++
 tb/tb_pipeline_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: RAW stalls via a shadow
// occupancy pipe, MEM redirect flushes, and halt -> drain -> MainMemory dump sequencing.
module pipeline_controller #(
  parameter int MEM_WORDS = 512
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        instr_valid_D,
  input  logic [4:0]  rs_addr_D,
  input  logic [4:0]  rt_addr_D,
  input  logic        uses_rs_D,
  input  logic        uses_rt_D,
  input  logic        wb_en_D,
  input  logic [4:0]  wb_addr_D,
  input  logic        halt_D,
  input  logic        redirect_M,
  input  logic        dump_ready,
  output logic        stall_F,
  output logic        stall_D,
  output logic        bubble_E,
  output logic        flush_D,
  output logic        flush_E,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, DRAIN, DUMP, DONE} state_t;

  typedef struct packed {
    logic       occ;
    logic       wr;
    logic [4:0] dst;
  } shadow_t;

  localparam logic [31:0] LAST_WORD = 32'(MEM_WORDS - 1);

  state_t      state_reg, state_next;
  shadow_t     e_reg, m_reg, w_reg;
  shadow_t     e_next, m_next, w_next;
  logic [31:0] cnt_reg, cnt_next;

  logic redirect_eff, match_rs, match_rt, hazard, issue, pipe_empty, dump_fire;

  function automatic logic hit(input shadow_t s, input logic [4:0] a);
    return s.wr && (s.dst == a);
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= RUN;
      e_reg     <= '0;
      m_reg     <= '0;
      w_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      e_reg     <= e_next;
      m_reg     <= m_next;
      w_reg     <= w_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    e_next     = '0;
    m_next     = e_reg;
    w_next     = m_reg;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    bubble_E   = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    halted     = 1'b0;

    // The pipe is already empty in DUMP/DONE, so a redirect there means nothing.
    redirect_eff = redirect_M & ((state_reg == RUN) | (state_reg == DRAIN));

    match_rs = (rs_addr_D != 5'd0) &&
               (hit(e_reg, rs_addr_D) || hit(m_reg, rs_addr_D) || hit(w_reg, rs_addr_D));
    match_rt = (rt_addr_D != 5'd0) &&
               (hit(e_reg, rt_addr_D) || hit(m_reg, rt_addr_D) || hit(w_reg, rt_addr_D));
    hazard   = instr_valid_D & ((uses_rs_D & match_rs) | (uses_rt_D & match_rt));
    issue    = (state_reg == RUN) & instr_valid_D & ~hazard & ~halt_D & ~redirect_M;

    pipe_empty = ~(e_reg.occ | m_reg.occ | w_reg.occ);
    dump_fire  = (state_reg == DUMP) & dump_ready;

    // Redirect squashes the EX instruction; the branch in MEM still retires.
    if (redirect_eff) begin
      m_next = '0;
    end else if (issue) begin
      e_next = {1'b1, wb_en_D & (wb_addr_D != 5'd0), wb_addr_D};
    end

    if (dump_fire) begin
      cnt_next = cnt_reg + 32'd1;
    end

    case (state_reg)
      RUN: begin
        if (instr_valid_D & halt_D & ~redirect_M) state_next = DRAIN;
      end
      DRAIN: begin
        if (redirect_M) begin
          state_next = RUN;
        end else if (pipe_empty) begin
          state_next = DUMP;
          cnt_next   = '0;
        end
      end
      DUMP: begin
        if (dump_fire && (cnt_reg == LAST_WORD)) state_next = DONE;
      end
      DONE: state_next = DONE;
    endcase

    // Outputs are forced low for as long as reset is held.
    if (RESET_N) begin
      flush_D    = redirect_eff;
      flush_E    = redirect_eff;
      stall_F    = ~redirect_eff & (hazard | halt_D | (state_reg != RUN));
      stall_D    = stall_F;
      bubble_E   = ~redirect_eff & ~issue;
      dump_valid = (state_reg == DUMP);
      dump_addr  = {cnt_reg[29:0], 2'b00};
      halted     = (state_reg == DONE);
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed test-plan steps followed by
// randomized cycles, every output compared each cycle against an issue-time model.
module tb_pipeline_controller;
  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        instr_valid_D = 1'b0;
  logic [4:0]  rs_addr_D = '0, rt_addr_D = '0, wb_addr_D = '0;
  logic        uses_rs_D = 1'b0, uses_rt_D = 1'b0, wb_en_D = 1'b0;
  logic        halt_D = 1'b0, redirect_M = 1'b0, dump_ready = 1'b0;
  logic        stall_F, stall_D, bubble_E, flush_D, flush_E, dump_valid, halted;
  logic [31:0] dump_addr;

  pipeline_controller #(.MEM_WORDS(N)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .instr_valid_D(instr_valid_D),
    .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D), .uses_rs_D(uses_rs_D),
    .uses_rt_D(uses_rt_D), .wb_en_D(wb_en_D), .wb_addr_D(wb_addr_D),
    .halt_D(halt_D), .redirect_M(redirect_M), .dump_ready(dump_ready),
    .stall_F(stall_F), .stall_D(stall_D), .bubble_E(bubble_E),
    .flush_D(flush_D), .flush_E(flush_E), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Model: each issued instruction is remembered with the cycle it left ID;
  // it sits in EX/MEM/WB during the three following cycles.
  typedef struct {
    int         ic;
    logic       wr;
    logic [4:0] dst;
  } flight_t;

  flight_t infl[$];
  int cyc = 0, mode = 0, words = 0;  // mode: 0 run, 1 drain, 2 dump, 3 done
  int checks = 0, errors = 0;
  logic last_stall, last_bubble, last_flush, last_dv, last_halted;
  logic [31:0] last_addr;

  function automatic bit reg_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (infl[i])
      if (infl[i].ic >= cyc - 3 && infl[i].wr && infl[i].dst == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pipe_empty();
    foreach (infl[i]) if (infl[i].ic >= cyc - 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    instr_valid_D = 0; rs_addr_D = 0; rt_addr_D = 0; uses_rs_D = 0; uses_rt_D = 0;
    wb_en_D = 0; wb_addr_D = 0; halt_D = 0; redirect_M = 0; dump_ready = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic us,
                           input logic ut, input logic we, input logic [4:0] wa);
    set_idle();
    instr_valid_D = 1; rs_addr_D = rs; rt_addr_D = rt; uses_rs_D = us; uses_rt_D = ut;
    wb_en_D = we; wb_addr_D = wa;
  endtask

  task automatic set_halt();
    set_idle();
    instr_valid_D = 1; halt_D = 1;
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic cycle();
    bit redir, hz, iss, empty;
    #1;
    redir = redirect_M && mode <= 1;
    hz    = instr_valid_D && ((uses_rs_D && reg_busy(rs_addr_D)) ||
                              (uses_rt_D && reg_busy(rt_addr_D)));
    iss   = mode == 0 && instr_valid_D && !hz && !halt_D && !redirect_M;
    chk("flush_D", flush_D, redir);
    chk("flush_E", flush_E, redir);
    chk("stall_F", stall_F, !redir && (hz || halt_D || mode != 0));
    chk("stall_D", stall_D, !redir && (hz || halt_D || mode != 0));
    chk("bubble_E", bubble_E, !redir && !iss);
    chk("dump_valid", dump_valid, mode == 2);
    chk("dump_addr", dump_addr, 32'(words * 4));
    chk("halted", halted, mode == 3);
    last_stall = stall_D; last_bubble = bubble_E; last_flush = flush_D;
    last_dv = dump_valid; last_addr = dump_addr; last_halted = halted;
    empty = pipe_empty();
    @(posedge CLK);
    if (redir) begin
      for (int i = 0; i < infl.size(); i++)
        if (infl[i].ic == cyc - 1) begin infl.delete(i); break; end
    end else if (iss) begin
      infl.push_back('{cyc, wb_en_D && wb_addr_D != 5'd0, wb_addr_D});
    end
    case (mode)
      0: if (instr_valid_D && halt_D && !redirect_M) mode = 1;
      1: if (redirect_M) mode = 0; else if (empty) begin mode = 2; words = 0; end
      2: if (dump_ready) begin if (words == N - 1) mode = 3; words++; end
      default: ;
    endcase
    cyc++;
    while (infl.size() > 0 && infl[0].ic < cyc - 3) void'(infl.pop_front());
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin set_idle(); cycle(); end
  endtask

  task automatic do_reset();
    set_idle();
    #2 RESET_N = 0;
    #1;
    chk("rst_stall_F", stall_F, 0);  chk("rst_stall_D", stall_D, 0);
    chk("rst_bubble_E", bubble_E, 0); chk("rst_flush_D", flush_D, 0);
    chk("rst_flush_E", flush_E, 0);  chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_addr", dump_addr, 0); chk("rst_halted", halted, 0);
    infl.delete(); mode = 0; words = 0;
    @(negedge CLK);
    RESET_N = 1;
  endtask

  // Holds one instruction in ID until it issues; returns the stall cycles seen.
  task automatic issue_count(input logic [4:0] rs, input logic [4:0] rt, input logic us,
                             input logic ut, input logic we, input logic [4:0] wa,
                             output int stalls);
    bit issued = 0;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      set_instr(rs, rt, us, ut, we, wa);
      cycle();
      if (!last_bubble) begin issued = 1; break; end
      if (last_stall) stalls++;
    end
    chk("issue_timeout", issued, 1);
  endtask

  task automatic wait_dump(output int n);
    bit got = 0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      set_halt();
      cycle();
      if (last_dv) begin got = 1; break; end
      n++;
    end
    chk("dump_entry_timeout", got, 1);
  endtask

  initial begin
    int s, n;
    int ready_pat[5] = '{1, 0, 1, 1, 1};
    int addr_pat[5]  = '{0, 4, 4, 8, 12};

    do_reset();

    // RAW back-to-back, then the $0 case
    issue_count(0, 0, 0, 0, 1, 5, s);
    issue_count(5, 0, 1, 0, 0, 0, s);
    chk("raw_b2b_stalls", s, 3);
    idle(4);
    issue_count(0, 0, 0, 0, 1, 0, s);
    issue_count(0, 0, 1, 0, 0, 0, s);
    chk("raw_r0_stalls", s, 0);

    // Distance sweep on $8
    for (int d = 1; d <= 3; d++) begin
      idle(4);
      issue_count(0, 0, 0, 0, 1, 8, s);
      for (int k = 0; k < d; k++) issue_count(0, 0, 0, 0, 1, 5'(20 + k), s);
      issue_count(0, 8, 0, 1, 0, 0, s);
      chk($sformatf("dist%0d_stalls", d), s, 3 - d);
    end

    // Redirect beats hazard and halt; the squashed writer no longer blocks
    idle(4);
    issue_count(0, 0, 0, 0, 1, 9, s);
    set_instr(9, 0, 1, 0, 0, 0); halt_D = 1; redirect_M = 1;
    cycle();
    chk("redir_flush", last_flush, 1);
    chk("redir_stall", last_stall, 0);
    issue_count(9, 0, 1, 0, 0, 0, s);
    chk("redir_squash_stalls", s, 0);

    // Halt drain with a full pipe, then dump handshake
    idle(4);
    for (int k = 1; k <= 3; k++) issue_count(0, 0, 0, 0, 1, 5'(k), s);
    set_halt(); cycle();
    chk("halt_stall", last_stall, 1);
    wait_dump(n);
    chk("drain_cycles", n, 3);
    chk("dump_first_addr", last_addr, 0);
    for (int k = 0; k < 5; k++) begin
      set_idle(); dump_ready = 1'(ready_pat[k]);
      cycle();
      chk($sformatf("dump_addr_step%0d", k), last_addr, 32'(addr_pat[k]));
    end
    idle(1);
    chk("done_halted", last_halted, 1);
    chk("done_dump_valid", last_dv, 0);

    // Redirect during DRAIN returns to RUN
    do_reset();
    for (int k = 1; k <= 3; k++) issue_count(0, 0, 0, 0, 1, 5'(k), s);
    set_halt(); cycle();
    set_halt(); cycle();
    set_halt(); redirect_M = 1; cycle();
    chk("drain_redir_flush", last_flush, 1);
    issue_count(0, 0, 0, 0, 0, 0, s);
    chk("drain_redir_run_stalls", s, 0);

    // Async reset mid-DUMP
    idle(4);
    set_halt(); cycle();
    wait_dump(n);
    set_idle(); dump_ready = 1; cycle();
    chk("mid_dump_valid", last_dv, 1);
    do_reset();
    issue_count(1, 2, 1, 1, 1, 3, s);
    chk("post_reset_stalls", s, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      if (mode == 3 && $urandom_range(0, 4) == 0) do_reset();
      set_idle();
      instr_valid_D = ($urandom_range(0, 3) != 0);
      rs_addr_D  = 5'($urandom_range(0, 7));
      rt_addr_D  = 5'($urandom_range(0, 7));
      uses_rs_D  = 1'($urandom_range(0, 1));
      uses_rt_D  = 1'($urandom_range(0, 1));
      wb_en_D    = 1'($urandom_range(0, 1));
      wb_addr_D  = 5'($urandom_range(0, 7));
      halt_D     = instr_valid_D && ($urandom_range(0, 39) == 0);
      redirect_M = ($urandom_range(0, 9) == 0);
      dump_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
